// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver: scans DIGITS hex digits with decimal points,
// per-digit blanking, leading-zero suppression and PWM brightness on the anodes.
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_BITS = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*DIGITS-1:0]    value,
  input  logic [DIGITS-1:0]      decimal_point,
  input  logic [DIGITS-1:0]      blank,
  input  logic                   suppress_zeros,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [DIGITS-1:0]      anode,
  output logic [7:0]             cathode
);

  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMP_W = PW + BRIGHT_BITS + 1;

  localparam logic [PW-1:0]     PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     INDEX_LAST    = IW'(DIGITS - 1);
  localparam logic [CMP_W-1:0]  DIV_W         = CMP_W'(REFRESH_DIV);
  localparam logic [DIGITS-1:0] ANODE_OFF     = {DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]        CATHODE_OFF   = {8{ACTIVE_LOW}};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]          prescale_q, prescale_d;
  logic [IW-1:0]          index_q, index_d;
  logic [PW-1:0]          phase_q;
  logic                   snap_valid_q;
  logic [4*DIGITS-1:0]    snap_value_q;
  logic [DIGITS-1:0]      snap_dp_q;
  logic [DIGITS-1:0]      snap_blank_q;
  logic                   snap_supp_q;
  logic [IW-1:0]          snap_idx_q;
  logic [DIGITS-1:0]      anode_q, anode_d;
  logic [7:0]             cathode_q, cathode_d;

  logic [DIGITS-1:0]      zero_from;
  logic [3:0]             nibble;
  logic                   suppressed;
  logic                   digit_on;
  logic [7:0]             cath_h;
  logic [DIGITS-1:0]      anode_h;
  logic [CMP_W-1:0]       phase_scaled;
  logic [CMP_W-1:0]       duty_limit;

  always_comb begin
    prescale_d = prescale_q + PW'(1);
    index_d    = index_q;
    if (prescale_q == PRESCALE_LAST) begin
      prescale_d = '0;
      index_d    = (index_q == INDEX_LAST) ? '0 : index_q + IW'(1);
    end
  end

  // zero_from[i]: every nibble from the leftmost digit down to digit i is zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
    assign zero_from[gi] = (snap_value_q[4*DIGITS-1:4*gi] == '0);
  end

  always_comb begin
    nibble     = snap_value_q[4*snap_idx_q +: 4];
    suppressed = snap_supp_q && (snap_idx_q != '0) && zero_from[snap_idx_q];
    digit_on   = 1'b0;
    cath_h     = 8'h00;
    if (snap_valid_q && !snap_blank_q[snap_idx_q]) begin
      if (suppressed) begin
        cath_h   = {snap_dp_q[snap_idx_q], 7'h00};
        digit_on = snap_dp_q[snap_idx_q];
      end else begin
        cath_h   = {snap_dp_q[snap_idx_q], seg_decode(nibble)};
        digit_on = 1'b1;
      end
    end
    // phase_q is the slot position of the cycle these registers will drive
    phase_scaled = CMP_W'(phase_q) << BRIGHT_BITS;
    duty_limit   = DIV_W * (CMP_W'(brightness) + CMP_W'(1));
    anode_h      = (digit_on && (phase_scaled < duty_limit)) ?
                   (DIGITS'(1) << snap_idx_q) : '0;
    anode_d      = anode_h ^ ANODE_OFF;
    cathode_d    = cath_h ^ CATHODE_OFF;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_q   <= '0;
      index_q      <= '0;
      phase_q      <= '0;
      snap_valid_q <= 1'b0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      snap_supp_q  <= 1'b0;
      snap_idx_q   <= '0;
      anode_q      <= ANODE_OFF;
      cathode_q    <= CATHODE_OFF;
    end else begin
      prescale_q <= prescale_d;
      index_q    <= index_d;
      phase_q    <= prescale_q;
      if (prescale_q == '0) begin
        snap_valid_q <= 1'b1;
        snap_value_q <= value;
        snap_dp_q    <= decimal_point;
        snap_blank_q <= blank;
        snap_supp_q  <= suppress_zeros;
        snap_idx_q   <= index_q;
      end
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: two instances (4- and 16-cycle slots) checked every
// cycle against a slot/phase arithmetic model of the display, plus directed spot checks.
module tb_seven_segment_scanner;

  localparam int DIGITS = 4;
  localparam int RA     = 4;
  localparam int RB     = 16;
  localparam int BB     = 4;
  localparam int HN     = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  decimal_point = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        suppress_zeros = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  anode_a, anode_b;
  logic [7:0]  cathode_a, cathode_b;

  always #5 clock = ~clock;

  seven_segment_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RA), .BRIGHT_BITS(BB), .ACTIVE_LOW(1'b1)) dut_a (
    .clock(clock), .reset(reset), .value(value), .decimal_point(decimal_point),
    .blank(blank), .suppress_zeros(suppress_zeros), .brightness(brightness),
    .anode(anode_a), .cathode(cathode_a)
  );

  seven_segment_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RB), .BRIGHT_BITS(BB), .ACTIVE_LOW(1'b1)) dut_b (
    .clock(clock), .reset(reset), .value(value), .decimal_point(decimal_point),
    .blank(blank), .suppress_zeros(suppress_zeros), .brightness(brightness),
    .anode(anode_b), .cathode(cathode_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] h_val [HN];
  logic [3:0]  h_dp  [HN];
  logic [3:0]  h_bl  [HN];
  logic [3:0]  h_br  [HN];
  logic        h_sz  [HN];
  logic [3:0]  obs_a_an [HN];
  logic [7:0]  obs_a_ca [HN];
  logic [3:0]  obs_b_an [HN];

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle n after reset release: output slot k=(n-2)/r shows digit k%4 using the
  // inputs present at cycle k*r, lit for phase (n-2)%r while phase*2^BB < r*(b+1).
  function automatic void model(input int r, input int n, output logic [3:0] an, output logic [7:0] ca);
    int k, slot, phase, d, s, nib;
    logic [15:0] v;
    logic on;
    logic [7:0] lit_h;
    an = 4'hF;
    ca = 8'hFF;
    if (n < 2) return;
    k = n - 2;
    slot = k / r;
    phase = k % r;
    d = slot % DIGITS;
    s = slot * r;
    v = h_val[s];
    nib = int'((v >> (4 * d)) & 16'hF);
    lit_h = 8'h00;
    on = 1'b0;
    if (!h_bl[s][d]) begin
      if (h_sz[s] && d > 0 && (v >> (4 * d)) == 16'h0) begin
        lit_h = {h_dp[s][d], 7'h00};
        on = h_dp[s][d];
      end else begin
        lit_h = {h_dp[s][d], seg_tab[nib][6:0]};
        on = 1'b1;
      end
    end
    if (on && (phase * (2 ** BB) < r * (int'(h_br[n-1]) + 1))) an = ~(4'b0001 << d);
    ca = ~lit_h;
  endfunction

  task automatic cycle_check();
    logic [3:0] ea;
    logic [7:0] eca;
    @(negedge clock);
    h_val[cyc] = value;
    h_dp[cyc]  = decimal_point;
    h_bl[cyc]  = blank;
    h_br[cyc]  = brightness;
    h_sz[cyc]  = suppress_zeros;
    obs_a_an[cyc] = anode_a;
    obs_a_ca[cyc] = cathode_a;
    obs_b_an[cyc] = anode_b;
    model(RA, cyc, ea, eca);
    chk($sformatf("a_anode c%0d", cyc), {4'h0, anode_a}, {4'h0, ea});
    chk($sformatf("a_cathode c%0d", cyc), cathode_a, eca);
    model(RB, cyc, ea, eca);
    chk($sformatf("b_anode c%0d", cyc), {4'h0, anode_b}, {4'h0, ea});
    chk($sformatf("b_cathode c%0d", cyc), cathode_b, eca);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    repeat (2) begin
      @(negedge clock);
      chk("rst_a_anode", {4'h0, anode_a}, 8'h0F);
      chk("rst_a_cathode", cathode_a, 8'hFF);
      chk("rst_b_anode", {4'h0, anode_b}, 8'h0F);
      chk("rst_b_cathode", cathode_b, 8'hFF);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle_check();
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(1, 15));
    return v;
  endfunction

  task automatic randomize_inputs();
    value          = rand_value();
    decimal_point  = 4'($urandom_range(0, 15));
    blank          = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    suppress_zeros = 1'($urandom_range(0, 1));
    brightness     = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int cnt;

    // single nonzero digit with leading-zero suppression
    value = 16'h0004; suppress_zeros = 1'b1; brightness = 4'hF; decimal_point = 4'h0; blank = 4'h0;
    do_reset();
    run(40);
    chk("lz_d0_anode", {4'h0, obs_a_an[2]}, 8'h0E);
    chk("lz_d0_cathode", obs_a_ca[2], 8'h99);
    chk("lz_d1_anode", {4'h0, obs_a_an[6]}, 8'h0F);
    chk("lz_d2_anode", {4'h0, obs_a_an[10]}, 8'h0F);
    chk("lz_d3_anode", {4'h0, obs_a_an[14]}, 8'h0F);

    // full scan order and hold time
    value = 16'h1234; suppress_zeros = 1'b0;
    do_reset();
    run(24);
    chk("scan_an_c2", {4'h0, obs_a_an[2]}, 8'h0E);
    chk("scan_an_c5", {4'h0, obs_a_an[5]}, 8'h0E);
    chk("scan_an_c6", {4'h0, obs_a_an[6]}, 8'h0D);
    chk("scan_an_c10", {4'h0, obs_a_an[10]}, 8'h0B);
    chk("scan_an_c14", {4'h0, obs_a_an[14]}, 8'h07);
    chk("scan_an_c18", {4'h0, obs_a_an[18]}, 8'h0E);
    chk("scan_ca_d0", obs_a_ca[2], 8'h99);
    chk("scan_ca_d1", obs_a_ca[6], 8'hB0);
    chk("scan_ca_d2", obs_a_ca[10], 8'hA4);
    chk("scan_ca_d3", obs_a_ca[14], 8'hF9);

    // brightness duty on the 16-cycle instance
    value = 16'h8888; brightness = 4'h0;
    do_reset();
    run(20);
    cnt = 0;
    for (int i = 2; i < 18; i++) if (obs_b_an[i] != 4'hF) cnt++;
    chk("duty_b0", cnt[7:0], 8'd1);
    brightness = 4'h7;
    do_reset();
    run(20);
    cnt = 0;
    for (int i = 2; i < 18; i++) if (obs_b_an[i] != 4'hF) cnt++;
    chk("duty_b7", cnt[7:0], 8'd8);

    // mid-slot input change is held off until the next slot
    value = 16'h0001; brightness = 4'hF; suppress_zeros = 1'b0;
    do_reset();
    run(2);
    value = 16'h0002;
    run(20);
    chk("snap_c2", obs_a_ca[2], 8'hF9);
    chk("snap_c5", obs_a_ca[5], 8'hF9);
    chk("snap_next", obs_a_ca[18], 8'hA4);

    // DP on a suppressed digit, blank on the top digit
    value = 16'h0000; decimal_point = 4'b0100; blank = 4'b1000; suppress_zeros = 1'b1;
    do_reset();
    run(18);
    chk("dp_d0_anode", {4'h0, obs_a_an[2]}, 8'h0E);
    chk("dp_d0_cathode", obs_a_ca[2], 8'hC0);
    chk("dp_d1_anode", {4'h0, obs_a_an[6]}, 8'h0F);
    chk("dp_d2_anode", {4'h0, obs_a_an[10]}, 8'h0B);
    chk("dp_d2_cathode", obs_a_ca[10], 8'h7F);
    chk("dp_d3_anode", {4'h0, obs_a_an[14]}, 8'h0F);

    // randomized traffic, then a reset in mid-scan and more traffic
    randomize_inputs();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) randomize_inputs();
      cycle_check();
    end
    randomize_inputs();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) randomize_inputs();
      cycle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised, time-multiplexed seven-segment display driver for the board's common-anode display. It scans DIGITS digits at a programmable refresh rate and decodes one 4-bit hex nibble per digit to segment patterns. It adds per-digit decimal point, per-digit blanking, leading-zero suppression and PWM brightness control. It sits between design logic (switches, counters, hash status) and the anode/cathode pins in top.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clock cycles per digit slot (>=4); 100000 gives 1 ms per digit at 100 MHz
BRIGHT_BITS, 4, width of brightness input
ACTIVE_LOW, 1, 1 means anode and cathode are driven active-low (on = 0)

Ports:
clock  in  1  system clock, 100 MHz on board
reset  in  1  synchronous, active-high reset
value  in  4*DIGITS  hex nibble per digit; digit i = value[4i+3:4i]; digit 0 is rightmost
decimal_point  in  DIGITS  DP enable per digit
blank  in  DIGITS  force digit i dark (anode inactive)
suppress_zeros  in  1  enable leading-zero suppression
brightness  in  BRIGHT_BITS  duty control; max value = full on
anode  out  DIGITS  digit enables, one-hot active
cathode  out  8  cathode[7]=DP, cathode[6:0]=segments g..a

Behaviour:
- Clock is one clock, named clock. Reset is synchronous and active-high, named reset.
- Reset values:
  - prescale = 0, index = 0, snapshot registers cleared.
  - anode = all inactive (all 1s when ACTIVE_LOW).
  - cathode = all off (8'hFF when ACTIVE_LOW).
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - When it wraps, index advances 0,1,...,DIGITS-1, then wraps to 0.
- Snapshot:
  - In the cycle where prescale==0, value, decimal_point, blank and suppress_zeros are captured.
  - Changes to these inputs mid-slot have no effect until the next slot start.
  - brightness is not snapshotted; it is sampled live each cycle.
- Output pipeline: anode/cathode are registered from the snapshot. Latency is 2 cycles from slot start to the digit appearing on the pins.
- Segment table, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Output is inverted when ACTIVE_LOW.
- Leading-zero suppression:
  - Digit i>0 is suppressed if suppress_zeros=1 and every nibble from DIGITS-1 down to i is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit has segments off. If decimal_point[i]=1 its anode stays active with only DP lit; otherwise its anode is inactive.
- Blank: blank[i]=1 makes anode inactive for the whole slot. This overrides DP and brightness.
- Brightness:
  - Anode is active only while (prescale << BRIGHT_BITS) < REFRESH_DIV*(brightness+1).
  - Evaluate at full width, with no overflow.
  - brightness = all ones is full-slot on; brightness = 0 is the minimum non-zero duty.
  - Cathode holds the digit pattern for the whole slot; only the anode is gated.
- At most one anode is active in any cycle, including during index wrap.
- Reset asserted mid-scan: the next cycle returns to reset values, and the scan restarts at digit 0 on release.

Test Plan:
- Reset with REFRESH_DIV=4, DIGITS=4 -> anode=4'b1111, cathode=8'hFF while reset=1 and on the first cycle after release.
- value=16'h0004, suppress_zeros=1, brightness=15, DP=0 -> digit0 slot: anode=4'b1110, cathode=8'h99; digits 1..3 slots: anode=4'b1111.
- value=16'h1234, suppress_zeros=0, brightness=15 -> anode sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; cathodes 99, B0, A4, F9 in that order.
- REFRESH_DIV=16, brightness=0, value=16'h8888 -> each slot has anode active exactly 1 of 16 cycles; brightness=7 gives 8 of 16.
- value changed from 16'h0001 to 16'h0002 two cycles into the digit0 slot -> cathode stays F9 for that slot; the next digit0 slot shows A4.
- decimal_point=4'b0100, blank=4'b1000, value=0, suppress_zeros=1 -> digit2 anode active with cathode=8'h7F (DP only); digit3 dark; digit0 shows C0.
